approx_pipelined_adder: RTL and testbench

- Parametrised, pipelined WIDTH-bit adder built from a per-bit full-adder cell.
- Each request selects exact or approximate mode. Approximate mode is lower-part-OR (LOA): the APPROX_BITS LSBs are OR-ed, not added.
- The carry chain is cut into SEG-bit segments, one register stage per segment, so the adder sustains one add per cycle at high clock rates.
- Sits between operand producers and accumulator/MAC blocks in the approximate datapath, with valid/ready handshakes on both sides.

---
 rtl/approx_pipelined_adder.sv | 107 ++++++++++
 tb/tb_approx_pipelined_adder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/approx_pipelined_adder.sv
// Pipelined WIDTH-bit adder with per-request lower-part-OR approximation.
// Entry 0 captures the request; entry k resolves segment k-1 and carries all bits forward.
module approx_pipelined_adder #(
    parameter int WIDTH       = 16,
    parameter int SEG         = 4,
    parameter int APPROX_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_approx
);

    localparam int STAGES = WIDTH / SEG;

    logic [STAGES:0]  v_q;
    logic [STAGES:0]  ap_q;
    logic [STAGES:0]  c_q;
    logic [WIDTH-1:0] a_q [0:STAGES-1];
    logic [WIDTH-1:0] b_q [0:STAGES-1];
    logic [WIDTH-1:0] s_q [0:STAGES];
    logic [WIDTH-1:0] s_d [1:STAGES];
    logic [STAGES:1]  c_d;
    logic             advance;

    // Full-adder cell returning {carry, sum}; a masked bit ORs and only the
    // topmost masked bit forwards a carry into the exact upper part.
    function automatic logic [1:0] fa_cell(input logic ai, input logic bi,
                                           input logic ci, input logic mi,
                                           input logic li);
        if (mi)
            return {li & ai & bi, ai | bi};
        return {(ai & bi) | (ai & ci) | (bi & ci), ai ^ bi ^ ci};
    endfunction

    // NOTE: combinational temporaries use blocking '=' and every output gets a
    // full default before the bit loop, so no latch can be inferred.
    always_comb begin
        logic       carry;
        logic [1:0] r;
        int         idx;
        carry = 1'b0;
        r     = 2'b00;
        idx   = 0;
        for (int k = 1; k <= STAGES; k++) begin
            s_d[k] = s_q[k-1];
            carry  = c_q[k-1];
            for (int j = 0; j < SEG; j++) begin
                idx = (k - 1) * SEG + j;
                r = fa_cell(a_q[k-1][idx], b_q[k-1][idx], carry,
                            ap_q[k-1] && (idx < APPROX_BITS),
                            idx == APPROX_BITS - 1);
                s_d[k][idx] = r[0];
                carry       = r[1];
            end
            c_d[k] = carry;
        end
    end

    // One global enable: the whole pipe moves unless the result is blocked.
    assign advance  = !v_q[STAGES] || out_ready;
    assign in_ready = advance;

    // NOTE: state registers use non-blocking '<=' and the data pipeline is reset
    // too, so sum/cout read as zero after reset rather than stale operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= '0;
            ap_q <= '0;
            c_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int k = 0; k <= STAGES; k++)
                s_q[k] <= '0;
        end else if (advance) begin
            v_q    <= {v_q[STAGES-1:0], in_valid};
            ap_q   <= {ap_q[STAGES-1:0], approx_en};
            c_q    <= {c_d, cin};
            a_q[0] <= in1;
            b_q[0] <= in2;
            s_q[0] <= '0;
            for (int k = 1; k < STAGES; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
            for (int k = 1; k <= STAGES; k++)
                s_q[k] <= s_d[k];
        end
    end

    assign out_valid  = v_q[STAGES];
    assign out_approx = ap_q[STAGES];
    assign sum        = s_q[STAGES];
    assign cout       = c_q[STAGES];

endmodule

// File: tb/tb_approx_pipelined_adder.sv
// Self-checking bench: arithmetic LOA reference model, scoreboard queue,
// stall-stability monitor and directed latency/reset/backpressure scenarios.
module tb_approx_pipelined_adder;

    localparam int W      = 16;
    localparam int SEG    = 4;
    localparam int AB     = 4;
    localparam int STAGES = W / SEG;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         cin;
    logic         approx_en;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         out_approx;

    approx_pipelined_adder #(.WIDTH(W), .SEG(SEG), .APPROX_BITS(AB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .cin(cin), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .out_approx(out_approx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ap;
        int           cyc;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: exact add, or OR of the low AB bits plus an exact add of the
    // upper bits with a single carry taken from bit AB-1.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic ap);
        longint lo, hi, cy, full;
        if (ap && AB > 0) begin
            lo   = longint'((a | b) & W'((1 << AB) - 1));
            cy   = longint'((a >> (AB - 1)) & (b >> (AB - 1)) & 1);
            hi   = longint'(a >> AB) + longint'(b >> AB) + cy;
            full = (hi << AB) | lo;
        end else begin
            full = longint'(a) + longint'(b) + longint'(ci);
        end
        return full[W:0];
    endfunction

    // Compare process: scoreboard, stall stability and post-reset state.
    logic         held = 1'b0;
    logic         post_rst = 1'b0;
    logic [W+1:0] held_val;
    always @(negedge clk) begin
        res_t e;
        res_t g;
        logic [W:0] r;
        cyc++;
        if (post_rst) begin
            check("post_reset_valid", {31'd0, out_valid}, 32'd0);
            check("post_reset_sum_cout", {15'd0, cout, sum}, 32'd0);
            post_rst = 1'b0;
        end
        if (rst) begin
            exp_q.delete();
            held     = 1'b0;
            post_rst = 1'b1;
        end else begin
            if (held && out_valid)
                check("stall_stable", {14'd0, out_approx, cout, sum}, {14'd0, held_val});
            held     = out_valid && !out_ready;
            held_val = {out_approx, cout, sum};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_sum_cout_mode", {14'd0, out_approx, cout, sum},
                          {14'd0, e.ap, e.co, e.s});
                end
                g.s = sum; g.co = cout; g.ap = out_approx; g.cyc = cyc;
                got_q.push_back(g);
            end
            if (in_valid && in_ready) begin
                r = ref_add(in1, in2, cin, approx_en);
                e.s = r[W-1:0]; e.co = r[W]; e.ap = approx_en; e.cyc = cyc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic ap);
        logic ok;
        int   tries;
        in1 = a; in2 = b; cin = ci; approx_en = ap; in_valid = 1'b1;
        tries = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!ok && tries < 50);
        check("send_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in1 = '0; in2 = '0; cin = 1'b0; approx_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_outputs", {14'd0, out_approx, cout, sum}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Pin the reference model with hand-computed values.
        check("model_exact_wrap",  32'(ref_add(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'h10000);
        check("model_loa_f_plus1", 32'(ref_add(16'h000F, 16'h0001, 1'b0, 1'b1)), 32'h0000F);
        check("model_loa_carry",   32'(ref_add(16'h0008, 16'h0008, 1'b0, 1'b1)), 32'h00018);
        check("model_cin_masked",  32'(ref_add(16'h1234, 16'h1111, 1'b1, 1'b1)), 32'h02345);
        check("model_cin_exact",   32'(ref_add(16'h1234, 16'h1111, 1'b1, 1'b0)), 32'h02346);
        check("model_loa_full",    32'(ref_add(16'hFFFF, 16'hFFFF, 1'b1, 1'b1)), 32'h1FFFF);

        // Exact wrap with exact latency.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (STAGES - 1) @(posedge clk);
        #1;
        check("latency_not_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        check("wrap_result", {14'd0, out_approx, cout, sum}, {14'd0, 1'b0, 1'b1, 16'h0000});
        idle_cycles(4);

        // Approx error cases and cin masking, back-to-back with mode changes.
        got_q.delete();
        send(16'h000F, 16'h0001, 1'b0, 1'b1);
        send(16'h0008, 16'h0008, 1'b0, 1'b1);
        send(16'h1234, 16'h1111, 1'b1, 1'b1);
        send(16'h1234, 16'h1111, 1'b1, 1'b0);
        idle_cycles(8);
        check("directed_count", got_q.size(), 32'd4);
        if (got_q.size() >= 4) begin
            check("loa_f_plus1", {15'd0, got_q[0].co, got_q[0].s}, {15'd0, 1'b0, 16'h000F});
            check("loa_carry", {16'd0, got_q[1].s}, 32'h0018);
            check("cin_masked", {15'd0, got_q[2].ap, got_q[2].s}, {15'd0, 1'b1, 16'h2345});
            check("cin_exact", {15'd0, got_q[3].ap, got_q[3].s}, {15'd0, 1'b0, 16'h2346});
            check("cin_consecutive", got_q[3].cyc - got_q[2].cyc, 32'd1);
        end

        // Streaming: 32 random requests, results on consecutive cycles.
        got_q.delete();
        for (int i = 0; i < 32; i++)
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        idle_cycles(8);
        check("stream_count", got_q.size(), 32'd32);
        if (got_q.size() == 32)
            check("stream_back_to_back", got_q[31].cyc - got_q[0].cyc, 32'd31);

        // Backpressure: fill, stall three cycles, then drain.
        got_q.delete();
        for (int i = 0; i < STAGES + 1; i++)
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        out_ready = 1'b0;
        in1 = W'($urandom); in2 = W'($urandom); approx_en = 1'b1; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        idle_cycles(10);
        check("backpressure_count", got_q.size(), 32'd10);

        // Reset with three requests in flight: none may ever emerge.
        got_q.delete();
        for (int i = 0; i < 3; i++)
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(12);
        check("reset_discard_count", got_q.size(), 32'd0);
        send(16'h8000, 16'h8000, 1'b1, 1'b0);
        idle_cycles(8);
        check("after_reset_count", got_q.size(), 32'd1);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
